// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache.
//
// Sits between the MEM stage and a multi-cycle backing memory. It takes one
// word load or store at a time, returns load data and stalls MEM (is_ready=0)
// while it writes back a dirty victim line or fills a line. Lines are
// 4 x 32-bit words, and the memory side moves whole lines.
//
// Ports:
//   clk, reset (async, active-low)
//   MEM side : is_input_valid, addr, mem_read, mem_write, din -> is_ready,
//              is_output_valid, dout, is_hit
//   Mem side : mem_req, mem_we, mem_addr (line address), mem_wdata <-
//              mem_ready (1-cycle pulse), mem_rdata
//
// Optional build macro DCACHE_STATS_EN adds saturating hit_count/miss_count.
module dcache_wb #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic [31:0]  dout,
    output logic         is_hit,
    output logic         mem_req,
    output logic         mem_we,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
`endif
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_WB, S_ALLOC} state_t;
    state_t state, state_n;

    // Latched request; addr[1:0] is never needed, so only the word address is kept.
    logic [29:0] req_word;
    logic [31:0] req_din;
    logic        req_wr;
    logic        req_missed;   // a fill happened for this request -> is_hit=0

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [127:0]         data_arr [NUM_LINES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [6:0]       req_bit;
    logic             accept;
    logic             lookup_hit;
    logic             victim_dirty;
    logic             unused_addr_lsb;

    assign req_idx         = req_word[2 +: IDX_W];
    assign req_tag         = req_word[29 -: TAG_W];
    assign req_bit         = {req_word[1:0], 5'b0};
    assign unused_addr_lsb = ^addr[1:0];

    assign accept       = (state == S_IDLE) && is_input_valid && (mem_read || mem_write);
    assign lookup_hit   = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state plus memory-side outputs, all decoded from state and latched regs.
    always_comb begin
        state_n   = state;
        is_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                is_ready = 1'b1;
                if (accept) state_n = S_TAG;
            end
            S_TAG: begin
                if (lookup_hit)        state_n = S_IDLE;
                else if (victim_dirty) state_n = S_WB;
                else                   state_n = S_ALLOC;
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[req_idx], req_idx};
                mem_wdata = data_arr[req_idx];
                if (mem_ready) state_n = S_ALLOC;
            end
            S_ALLOC: begin
                mem_req  = 1'b1;
                mem_addr = req_word[29:2];
                if (mem_ready) state_n = S_TAG;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid           <= '0;
            dirty           <= '0;
            req_word        <= '0;
            req_din         <= '0;
            req_wr          <= 1'b0;
            req_missed      <= 1'b0;
            is_output_valid <= 1'b0;
            is_hit          <= 1'b0;
            dout            <= '0;
        end else begin
            is_output_valid <= 1'b0;
            is_hit          <= 1'b0;
            if (accept) begin
                req_word   <= addr[31:2];
                req_din    <= din;
                req_wr     <= mem_write;
                req_missed <= 1'b0;
            end
            if (state == S_TAG && lookup_hit) begin
                is_output_valid <= 1'b1;
                is_hit          <= !req_missed;
                dout            <= req_wr ? 32'd0 : data_arr[req_idx][req_bit +: 32];
                if (req_wr) dirty[req_idx] <= 1'b1;
            end
            if (state == S_WB && mem_ready) dirty[req_idx] <= 1'b0;
            if (state == S_ALLOC && mem_ready) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
                req_missed     <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset: valid bits gate every use, and writes
    // only happen in TAG/ALLOC, which reset forces the FSM out of.
    always_ff @(posedge clk) begin
        if (state == S_ALLOC && mem_ready) begin
            data_arr[req_idx] <= mem_rdata;
            tag_arr[req_idx]  <= req_tag;
        end
        if (state == S_TAG && lookup_hit && req_wr)
            data_arr[req_idx][req_bit +: 32] <= req_din;
    end

`ifdef DCACHE_STATS_EN
    // Only the first lookup of a request counts; the re-lookup after a fill
    // has req_missed set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_TAG && !req_missed) begin
            if (lookup_hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
module tb_dcache_wb;
    localparam int NL = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  din = '0;
    logic         is_ready, is_output_valid, is_hit, mem_req, mem_we;
    logic [31:0]  dout;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    dcache_wb #(.NUM_LINES(NL)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
        .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- backing memory + responder ----------------
    typedef struct { logic we; logic [27:0] a; logic [127:0] wd; } ev_t;
    ev_t evq[$];
    ev_t rsp_ev;
    logic [127:0] back_mem [logic [27:0]];
    int  lat_cfg = 2;
    bit  mem_hold = 0;
    int  lat_cnt = 0;

    function automatic logic [127:0] back_line(input logic [27:0] la);
        if (back_mem.exists(la)) return back_mem[la];
        return {la, 2'd3, 2'b10, la, 2'd2, 2'b10, la, 2'd1, 2'b10, la, 2'd0, 2'b10};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            mem_ready = 1'b0;
            lat_cnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            lat_cnt = 0;
        end else if (mem_req && !mem_hold) begin
            lat_cnt++;
            if (lat_cnt >= lat_cfg) begin
                rsp_ev.we = mem_we; rsp_ev.a = mem_addr; rsp_ev.wd = mem_wdata;
                evq.push_back(rsp_ev);
                if (mem_we) back_mem[mem_addr] = mem_wdata;
                else        mem_rdata = back_line(mem_addr);
                mem_ready = 1'b1;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // ---------------- reference model ----------------
    // Architectural word values plus which line each direct-mapped slot holds.
    logic [31:0] ref_words [logic [29:0]];
    bit          ref_v [NL];
    bit          ref_d [NL];
    logic [27:0] ref_la [NL];
    int          ref_hits = 0;
    int          ref_misses = 0;

    function automatic logic [31:0] ref_word(input logic [29:0] w);
        logic [127:0] l;
        if (ref_words.exists(w)) return ref_words[w];
        l = back_line(w[29:2]);
        return l[{w[1:0], 5'b0} +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin ref_v[i] = 0; ref_d[i] = 0; ref_la[i] = '0; end
        ref_words.delete();
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] ed, output bit eh, output bit ewb,
                                output logic [27:0] wa, output logic [127:0] wl,
                                output logic [27:0] aa);
        int idx;
        idx = int'(a[31:4]) % NL;
        eh  = ref_v[idx] && ref_la[idx] == a[31:4];
        ewb = !eh && ref_v[idx] && ref_d[idx];
        wa  = ref_la[idx];
        for (int w = 0; w < 4; w++) wl[w*32 +: 32] = ref_word({ref_la[idx], 2'(w)});
        aa  = a[31:4];
        if (eh) ref_hits++; else ref_misses++;
        if (!eh) begin ref_v[idx] = 1; ref_d[idx] = 0; ref_la[idx] = a[31:4]; end
        if (wr) begin
            ref_words[a[31:2]] = d;
            ref_d[idx] = 1;
            ed = 32'd0;
        end else begin
            ed = ref_word(a[31:2]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] gd, output bit gh, output int lat,
                             output bit tmo);
        tmo = 0; lat = 0; gd = '0; gh = 0;
        evq.delete();
        @(negedge clk);
        for (int i = 0; i < 50 && is_ready !== 1'b1; i++) @(negedge clk);
        if (is_ready !== 1'b1) begin tmo = 1; return; end
        is_input_valid = 1; addr = a; mem_read = !wr; mem_write = wr; din = d;
        @(posedge clk); #1;
        is_input_valid = 0; mem_read = 0; mem_write = 0; addr = $urandom; din = $urandom;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (is_output_valid === 1'b1) break;
            if (lat > 500) begin tmo = 1; break; end
        end
        gd = dout; gh = is_hit;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            checks++; if (is_ready !== 1'b1) begin failures++; $display("FAIL rst_ready[%0d] got=%b exp=1", p, is_ready); end
            checks++; if (is_output_valid !== 1'b0) begin failures++; $display("FAIL rst_ov[%0d] got=%b exp=0", p, is_output_valid); end
            checks++; if (is_hit !== 1'b0) begin failures++; $display("FAIL rst_hit[%0d] got=%b exp=0", p, is_hit); end
            checks++; if (dout !== 32'd0) begin failures++; $display("FAIL rst_dout[%0d] got=%h exp=0", p, dout); end
            checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_req[%0d] got=%b%b exp=00", p, mem_req, mem_we); end
            checks++; if (mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin failures++; $display("FAIL rst_maddr[%0d] got=%h/%h exp=0", p, mem_addr, mem_wdata); end
`ifdef DCACHE_STATS_EN
            checks++; if (hit_count !== 0 || miss_count !== 0) begin failures++; $display("FAIL rst_stats[%0d] got=%0d/%0d exp=0/0", p, hit_count, miss_count); end
`endif
            if (p == 0) begin reset = 1; @(posedge clk); #1; end
        end
    endtask

    task automatic test_cold_load();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        lat_cfg = 5;
        back_mem[28'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
        model_access(0, 32'h100, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h100, 0, gd, gh, lat, tmo);
        checks++; if (tmo || gd !== ed) begin failures++; $display("FAIL cold_dout got=%h exp=%h tmo=%0d", gd, ed, tmo); end
        checks++; if (gh !== 1'b0) begin failures++; $display("FAIL cold_hit got=%b exp=0", gh); end
        checks++; if (evq.size() != 1 || evq[0].we !== 1'b0 || evq[0].a !== 28'h10) begin
            failures++; $display("FAIL cold_alloc got_n=%0d exp one read of 0000010", evq.size()); end
        model_access(0, 32'h104, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h104, 0, gd, gh, lat, tmo);
        checks++; if (tmo || gd !== ed) begin failures++; $display("FAIL hit_dout got=%h exp=%h", gd, ed); end
        checks++; if (gh !== 1'b1) begin failures++; $display("FAIL hit_flag got=%b exp=1", gh); end
        checks++; if (lat != 1) begin failures++; $display("FAIL hit_latency got=%0d exp=1", lat); end
        checks++; if (evq.size() != 0) begin failures++; $display("FAIL hit_memtraffic got=%0d exp=0", evq.size()); end
        @(posedge clk); #1;
        checks++; if (is_output_valid !== 1'b0) begin failures++; $display("FAIL ov_pulse got=%b exp=0", is_output_valid); end
    endtask

    task automatic test_store_evict();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        lat_cfg = 3;
        model_access(1, 32'h108, 32'hDEADBEEF, ed, eh, ewb, wa, wl, aa);
        do_access(1, 32'h108, 32'hDEADBEEF, gd, gh, lat, tmo);
        checks++; if (tmo || gh !== 1'b1 || gd !== 32'd0) begin failures++; $display("FAIL st_hit got=%b/%h exp=1/0", gh, gd); end
        model_access(0, 32'h508, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h508, 0, gd, gh, lat, tmo);
        checks++; if (evq.size() != 2) begin failures++; $display("FAIL evict_n got=%0d exp=2", evq.size()); end
        else begin
            checks++; if (evq[0].we !== 1'b1 || evq[0].a !== 28'h10 || evq[0].wd[95:64] !== 32'hDEADBEEF || evq[0].wd !== wl) begin
                failures++; $display("FAIL evict_wb got=%b/%h/%h exp=1/0000010/%h", evq[0].we, evq[0].a, evq[0].wd, wl); end
            checks++; if (evq[1].we !== 1'b0 || evq[1].a !== 28'h50) begin
                failures++; $display("FAIL evict_alloc got=%b/%h exp=0/0000050", evq[1].we, evq[1].a); end
        end
        checks++; if (tmo || gd !== ed || gh !== 1'b0) begin failures++; $display("FAIL evict_dout got=%h/%b exp=%h/0", gd, gh, ed); end
    endtask

    task automatic test_store_miss();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        model_access(1, 32'h200, 32'h55, ed, eh, ewb, wa, wl, aa);
        do_access(1, 32'h200, 32'h55, gd, gh, lat, tmo);
        checks++; if (evq.size() != 1 || evq[0].we !== 1'b0 || evq[0].a !== 28'h20) begin
            failures++; $display("FAIL stmiss_alloc got_n=%0d exp one read of 0000020", evq.size()); end
        checks++; if (tmo || gh !== 1'b0) begin failures++; $display("FAIL stmiss_hit got=%b exp=0", gh); end
        model_access(0, 32'h200, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h200, 0, gd, gh, lat, tmo);
        checks++; if (tmo || gd !== 32'h55 || gh !== 1'b1) begin failures++; $display("FAIL stmiss_load got=%h/%b exp=00000055/1", gd, gh); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed, ea; bit eh, ewb, seen; logic [27:0] wa, aa; logic [127:0] wl; int bad;
        ea = 32'h0000_3048;
        model_access(0, ea, 0, ed, eh, ewb, wa, wl, aa);
        evq.delete(); mem_hold = 1;
        @(negedge clk); is_input_valid = 1; addr = ea; mem_read = 1; mem_write = 0;
        @(posedge clk); #1; is_input_valid = 0; mem_read = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(posedge clk); #1; seen = (mem_req === 1'b1); end
        checks++; if (!seen) begin failures++; $display("FAIL bp_req got=0 exp=1"); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            is_input_valid = 1'($urandom_range(0, 1)); addr = $urandom; mem_read = 1; din = $urandom;
            @(posedge clk); #1;
            if (is_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== ea[31:4] || is_output_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
        @(negedge clk); is_input_valid = 0; mem_read = 0; mem_hold = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = (is_output_valid === 1'b1); end
        checks++; if (!seen || dout !== ed || is_hit !== 1'b0) begin
            failures++; $display("FAIL bp_result got=%0d/%h/%b exp=1/%h/0", seen, dout, is_hit, ed); end
        checks++; if (evq.size() != 1) begin failures++; $display("FAIL bp_memtraffic got=%0d exp=1", evq.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        model_access(1, 32'hFFFF_FFFC, 32'hA5A5A5A5, ed, eh, ewb, wa, wl, aa);
        do_access(1, 32'hFFFF_FFFC, 32'hA5A5A5A5, gd, gh, lat, tmo);
        checks++; if (evq.size() != 1 || evq[0].a !== 28'hFFFFFFF) begin failures++; $display("FAIL wrap_alloc got_n=%0d exp one read of FFFFFFF", evq.size()); end
        model_access(0, 32'h0000_00FC, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h0000_00FC, 0, gd, gh, lat, tmo);
        checks++; if (evq.size() != 2 || evq[0].we !== 1'b1 || evq[0].a !== 28'hFFFFFFF ||
                      evq[0].wd[127:96] !== 32'hA5A5A5A5 || evq[1].a !== 28'h000000F) begin
            failures++; $display("FAIL wrap_evict got_n=%0d exp WB FFFFFFF then read 000000F", evq.size()); end
        model_access(0, 32'hFFFF_FFFC, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'hFFFF_FFFC, 0, gd, gh, lat, tmo);
        checks++; if (tmo || gd !== 32'hA5A5A5A5 || gh !== 1'b0) begin failures++; $display("FAIL wrap_load got=%h/%b exp=a5a5a5a5/0", gd, gh); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, ed, gd; bit wr, eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl;
        int lat, nexp;
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'h1000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            d  = $urandom;
            lat_cfg = $urandom_range(1, 4);
            model_access(wr, a, d, ed, eh, ewb, wa, wl, aa);
            do_access(wr, a, d, gd, gh, lat, tmo);
            nexp = eh ? 0 : (ewb ? 2 : 1);
            checks++; if (tmo || gd !== ed) begin failures++; $display("FAIL rnd_dout[%0d] a=%h got=%h exp=%h tmo=%0d", n, a, gd, ed, tmo); end
            checks++; if (gh !== eh) begin failures++; $display("FAIL rnd_hit[%0d] a=%h got=%b exp=%b", n, a, gh, eh); end
            checks++; if (evq.size() != nexp) begin failures++; $display("FAIL rnd_nev[%0d] a=%h got=%0d exp=%0d", n, a, evq.size(), nexp); end
            else if (nexp > 0) begin
                if (ewb) begin
                    checks++; if (evq[0].we !== 1'b1 || evq[0].a !== wa || evq[0].wd !== wl) begin
                        failures++; $display("FAIL rnd_wb[%0d] got=%h/%h exp=%h/%h", n, evq[0].a, evq[0].wd, wa, wl); end
                end
                checks++; if (evq[nexp-1].we !== 1'b0 || evq[nexp-1].a !== aa) begin
                    failures++; $display("FAIL rnd_alloc[%0d] got=%b/%h exp=0/%h", n, evq[nexp-1].we, evq[nexp-1].a, aa); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo, seen; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        lat_cfg = 2;
        model_access(1, 32'h104, 32'h77, ed, eh, ewb, wa, wl, aa);
        do_access(1, 32'h104, 32'h77, gd, gh, lat, tmo);
        mem_hold = 1; evq.delete();
        @(negedge clk); is_input_valid = 1; addr = 32'h904; mem_read = 1;
        @(posedge clk); #1; is_input_valid = 0; mem_read = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(posedge clk); #1; seen = (mem_req === 1'b1 && mem_we === 1'b1); end
        checks++; if (!seen) begin failures++; $display("FAIL ar_wb_start got=0 exp=1"); end
        @(posedge clk); #3;
        reset = 0; #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL ar_req got=%b/%b exp=0/0", mem_req, mem_we); end
        checks++; if (is_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", is_ready); end
        model_reset();
        @(negedge clk); #1; reset = 1; mem_hold = 0;
        model_access(0, 32'h104, 0, ed, eh, ewb, wa, wl, aa);
        do_access(0, 32'h104, 0, gd, gh, lat, tmo);
        checks++; if (evq.size() != 1 || evq[0].we !== 1'b0 || evq[0].a !== 28'h10) begin
            failures++; $display("FAIL ar_refill got_n=%0d exp one read of 0000010", evq.size()); end
        checks++; if (tmo || gh !== 1'b0 || gd !== ed) begin failures++; $display("FAIL ar_load got=%h/%b exp=%h/0", gd, gh, ed); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] ed, gd; bit eh, ewb, gh, tmo; logic [27:0] wa, aa; logic [127:0] wl; int lat;
        logic [31:0] seq [3];
        seq[0] = 32'h104; seq[1] = 32'h904; seq[2] = 32'h908;
        for (int i = 0; i < 3; i++) begin
            model_access(0, seq[i], 0, ed, eh, ewb, wa, wl, aa);
            do_access(0, seq[i], 0, gd, gh, lat, tmo);
        end
        checks++; if (hit_count !== 32'(ref_hits) || miss_count !== 32'(ref_misses)) begin
            failures++; $display("FAIL stats got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, ref_hits, ref_misses); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_cold_load();
        test_store_evict();
        test_store_miss();
        test_backpressure();
        test_wrap();
        test_random();
        test_async_reset();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a multi-cycle backing data memory.
- Accepts one word load/store at a time from MEM and returns load data.
- Stalls MEM via is_ready while it writes back a dirty victim line or fills a line.
- Line = 4 words (128 bits); memory side moves whole lines over a req/ready handshake.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, 2..256; IDX_W = log2(NUM_LINES).
- TAG_W, 28-IDX_W, derived, not overridable; tag = addr[31:4+IDX_W].

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- is_input_valid  input  1  MEM-stage request present
- addr  input  32  byte address; [1:0] ignored, [3:2] word offset, [4+:IDX_W] index
- mem_read  input  1  load request
- mem_write  input  1  store request (mem_read and mem_write never both 1)
- din  input  32  store data
- is_ready  output  1  cache can accept a request this cycle
- is_output_valid  output  1  dout valid (loads) / store completed
- dout  output  32  load data
- is_hit  output  1  qualifies is_output_valid: access hit on first lookup
- mem_req  output  1  backing-memory request
- mem_we  output  1  1 = line write, 0 = line read
- mem_addr  output  28  line address (addr[31:4])
- mem_wdata  output  128  victim line, word 0 in [31:0]
- mem_ready  input  1  one-cycle pulse: write accepted, or mem_rdata valid
- mem_rdata  input  128  fill line, word 0 in [31:0]

Behaviour:
- Reset (reset==0, async): all valid and dirty bits 0; FSM in IDLE.
- Reset values: is_ready=1, is_output_valid=0, is_hit=0, dout=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request capture: in IDLE with is_input_valid && (mem_read||mem_write), latch addr, din and type on the clock edge; go to TAG. The requester need not hold the request afterwards.
- is_ready=1 only in IDLE.
- TAG state (lookup of the latched request):
  - Hit: is_output_valid=1 for exactly one cycle; dout = selected word (load) or 0 (store); is_hit=1 if no miss occurred for this request.
  - Store hit: word written, dirty set on the same edge.
  - After a hit: back to IDLE.
  - Miss with victim valid&&dirty: go to WB.
  - Otherwise miss: go to ALLOC.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim line; hold all until mem_ready; then clear dirty, go to ALLOC.
- ALLOC: mem_req=1, mem_we=0, mem_addr=latched addr[31:4]; hold until mem_ready; on that edge write mem_rdata into the line, set valid=1 and dirty=0, update tag, flag miss; go to TAG (which then hits, with is_hit=0).
- Latency: hit = output 1 cycle after accept; clean miss = 2 + memory read latency; dirty miss adds memory write latency.
- mem_ready outside WB/ALLOC: ignored.
- mem_req drops combinationally on async reset; the backing memory tolerates an aborted request.
- is_input_valid while is_ready=0: ignored, no side effects.
- Address wrap: 0xFFFF_FFFC maps to index all-ones, tag all-ones; no special case.
- Output timing: is_output_valid, is_hit and dout are registered; mem_* are decoded from FSM state and latched registers.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - Counting happens on the first TAG lookup of each request: hit_count += 1 on a hit, miss_count += 1 on a miss.
  - Counters saturate at 0xFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Cold load: after reset, load addr 0x100, memory returns line {4,3,2,1} after 5 cycles. Required: one ALLOC with mem_addr=0x0000010; then dout=1, is_hit=0; a second load to 0x104 gives dout=2, is_hit=1, one cycle after accept.
- Store hit then dirty eviction:
  - Store 0xDEADBEEF to 0x108 (hit), then load 0x508 (same index, different tag, NUM_LINES=16).
  - Required: WB with mem_addr=0x0000010 and mem_wdata[95:64]=0xDEADBEEF, then ALLOC with mem_addr=0x0000050.
- Store miss (write-allocate): store 0x55 to clean-miss 0x200, then load 0x200 -> ALLOC then dout=0x55; no WB.
- Backpressure: mem_ready held low for 20 cycles in ALLOC -> is_ready=0 and mem_req=1 throughout; new is_input_valid pulses change nothing.
- Async reset mid-WB: reset=0 between clock edges -> mem_req=0 and is_ready=1 immediately; a following load to the previously cached 0x104 misses (ALLOC issued).
- With DCACHE_STATS_EN: sequence hit, miss, hit -> hit_count=2, miss_count=1.
